// File: rtl/bat_pkg.sv
// Shared constants for the register bank: bus width, register count and fixed register indices.
package bat_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int REG_A    = 0;
  localparam int REG_B    = 1;
  localparam int REG_OUT  = 7;
endpackage

// File: rtl/bat_reg_bank_if.sv
// Register-control interface between the controller (master) and the register bank (slave),
// including the output-device valid/ready handshake.
interface bat_reg_bank_if #(
  parameter int DATA_W = bat_pkg::DATA_W
);
  logic [bat_pkg::NUM_REGS-1:0] regs_inc;
  logic [bat_pkg::NUM_REGS-1:0] regs_rw;
  logic [bat_pkg::NUM_REGS-1:0] regs_en;
  logic [DATA_W-1:0]            bus_in;
  logic [DATA_W-1:0]            bus_out;
  logic                         bus_oe;
  logic [DATA_W-1:0]            a_q;
  logic [DATA_W-1:0]            b_q;
  logic [DATA_W-1:0]            out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         bus_conflict;
  logic                         out_ovf;

  modport master (
    output regs_inc, regs_rw, regs_en, bus_in, out_ready,
    input  bus_out, bus_oe, a_q, b_q, out_data, out_valid, bus_conflict, out_ovf
  );

  modport slave (
    input  regs_inc, regs_rw, regs_en, bus_in, out_ready,
    output bus_out, bus_oe, a_q, b_q, out_data, out_valid, bus_conflict, out_ovf
  );
endinterface

// File: rtl/bat_out_fifo.sv
// Output queue for writes to OUT. BAT_REG_OUT_FIFO_EN selects a DEPTH-entry circular FIFO;
// otherwise a single holding register is used and DEPTH is ignored.
module bat_out_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              drop_o
);
`ifdef BAT_REG_OUT_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, rd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] last_q;
  logic              empty, full, pop, push_ok;

  // Extra wrap bit on the pointers separates full (wrap differs) from empty (wrap equal).
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && pop_ready_i;
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;

  assign out_valid_o = !empty;
  assign out_data_o  = empty ? last_q : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (pop) begin
        last_q <= mem_q[rd_q[AW-1:0]];
        rd_q   <= rd_q + (AW+1)'(1);
      end
    end
  end
`else
  localparam int unused_depth = DEPTH;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pop, push_ok;

  assign pop     = valid_q && pop_ready_i;
  assign push_ok = push_i && (!valid_q || pop);
  assign drop_o  = push_i && valid_q && !pop;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (push_ok) begin
      data_d  = push_data_i;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
`endif
endmodule

// File: rtl/bat_reg_bank.sv
// Eight-register bus responder: per-register increment/load/read, lowest-index read arbitration,
// sticky conflict/overflow flags, OUT writes queued via bat_out_fifo (BAT_REG_OUT_FIFO_EN).
module bat_reg_bank #(
  parameter int DATA_W    = bat_pkg::DATA_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  bat_reg_bank_if.slave  bus_if
);
  import bat_pkg::NUM_REGS;
  import bat_pkg::REG_A;
  import bat_pkg::REG_B;
  import bat_pkg::REG_OUT;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en, readers;
  logic [DATA_W-1:0]   bus_out_d;
  logic                multi_rd;
  logic                conflict_q, ovf_q;
  logic                fifo_drop;

  // Increment wins over load; a register with RW=1 never changes.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (bus_if.regs_inc[i] && !bus_if.regs_rw[i]) begin
        regs_d[i] = regs_q[i] + DATA_W'(1);
      end else if (bus_if.regs_en[i] && !bus_if.regs_rw[i]) begin
        regs_d[i] = bus_if.bus_in;
      end
    end
  end

  assign wr_en    = (bus_if.regs_inc | bus_if.regs_en) & ~bus_if.regs_rw;
  assign readers  = bus_if.regs_en & bus_if.regs_rw;
  assign multi_rd = |(readers & (readers - NUM_REGS'(1)));

  // Scan downwards so the lowest-index reader is the last assignment and wins.
  always_comb begin
    bus_out_d = '0;
    for (int i = NUM_REGS-1; i >= 0; i--) begin
      if (readers[i]) bus_out_d = regs_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      conflict_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      conflict_q <= conflict_q | multi_rd;
      ovf_q      <= ovf_q | fifo_drop;
    end
  end

  bat_out_fifo #(
    .DEPTH  (OUT_DEPTH),
    .DATA_W (DATA_W)
  ) u_out_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (wr_en[REG_OUT]),
    .push_data_i (regs_d[REG_OUT]),
    .pop_ready_i (bus_if.out_ready),
    .out_data_o  (bus_if.out_data),
    .out_valid_o (bus_if.out_valid),
    .drop_o      (fifo_drop)
  );

  assign bus_if.bus_out      = bus_out_d;
  assign bus_if.bus_oe       = |readers;
  assign bus_if.a_q          = regs_q[REG_A];
  assign bus_if.b_q          = regs_q[REG_B];
  assign bus_if.bus_conflict = conflict_q;
  assign bus_if.out_ovf      = ovf_q;
endmodule

// File: tb/tb_bat_reg_bank.sv
// Self-checking bench for bat_reg_bank: directed scenarios then random traffic against a
// queue-based reference model. Honors BAT_REG_OUT_FIFO_EN for the expected queue capacity.
module tb_bat_reg_bank;
`ifdef BAT_REG_OUT_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bat_reg_bank_if bif ();

  bat_reg_bank #(.DATA_W(8), .OUT_DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bif)
  );

  logic [7:0] m_reg [8];
  logic [7:0] m_q [$];
  logic [7:0] m_last;
  logic       m_conf, m_ovf;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_q.delete();
    m_last = 8'h00;
    m_conf = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge();
    logic [7:0] rd;
    logic       pop, wr7;
    int         sz;
    rd = bif.regs_en & bif.regs_rw;
    if ($countones(rd) > 1) m_conf = 1'b1;
    sz  = m_q.size();
    pop = (sz > 0) && bif.out_ready;
    wr7 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!bif.regs_rw[i]) begin
        if (bif.regs_inc[i]) begin
          m_reg[i] = m_reg[i] + 8'd1;
          if (i == 7) wr7 = 1'b1;
        end else if (bif.regs_en[i]) begin
          m_reg[i] = bif.bus_in;
          if (i == 7) wr7 = 1'b1;
        end
      end
    end
    if (pop) m_last = m_q.pop_front();
    if (wr7) begin
      if (sz < CAP || pop) m_q.push_back(m_reg[7]);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [7:0] rd, exp_out;
    rd = bif.regs_en & bif.regs_rw;
    exp_out = 8'h00;
    for (int i = 7; i >= 0; i--) if (rd[i]) exp_out = m_reg[i];
    chk("bus_oe", bif.bus_oe, rd != 8'h00);
    chk("bus_out", bif.bus_out, exp_out);
    chk("a_q", bif.a_q, m_reg[0]);
    chk("b_q", bif.b_q, m_reg[1]);
    chk("out_valid", bif.out_valid, m_q.size() != 0);
    chk("out_data", bif.out_data, (m_q.size() != 0) ? m_q[0] : m_last);
    chk("bus_conflict", bif.bus_conflict, m_conf);
    chk("out_ovf", bif.out_ovf, m_ovf);
  endtask

  task automatic drive(input logic [7:0] inc, input logic [7:0] rw, input logic [7:0] en,
                       input logic [7:0] bin, input logic rdy);
    bif.regs_inc  = inc;
    bif.regs_rw   = rw;
    bif.regs_en   = en;
    bif.bus_in    = bin;
    bif.out_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cyc(input logic [7:0] inc, input logic [7:0] rw, input logic [7:0] en,
                     input logic [7:0] bin, input logic rdy);
    drive(inc, rw, en, bin, rdy);
    check_all();
    step();
  endtask

  // Reset asserted between edges; outputs must clear before the next posedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_valid", bif.out_valid, 1'b0);
    chk("arst_a", bif.a_q, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    bif.regs_inc = '0; bif.regs_rw = '0; bif.regs_en = '0;
    bif.bus_in = '0; bif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check_all();
    chk("rst_oe", bif.bus_oe, 1'b0);
    chk("rst_bus_out", bif.bus_out, 8'h00);
    step();

    cyc(8'h00, 8'h00, 8'h04, 8'h5A, 1'b0);
    drive(8'h00, 8'h04, 8'h04, 8'h00, 1'b0);
    check_all();
    chk("r3_read", bif.bus_out, 8'h5A);
    chk("r3_oe", bif.bus_oe, 1'b1);
    step();

    cyc(8'h00, 8'h00, 8'h01, 8'hFF, 1'b0);
    cyc(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("a_wrap", bif.a_q, 8'h00);
    step();
    cyc(8'h00, 8'h00, 8'h02, 8'h03, 1'b0);
    cyc(8'h02, 8'h00, 8'h02, 8'h10, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("b_inc_over_load", bif.b_q, 8'h04);
    step();

    cyc(8'h00, 8'h00, 8'h02, 8'h11, 1'b0);
    cyc(8'h00, 8'h00, 8'h04, 8'h22, 1'b0);
    drive(8'h00, 8'h06, 8'h06, 8'h00, 1'b0);
    check_all();
    chk("conf_low_wins", bif.bus_out, 8'h11);
    chk("conf_not_yet", bif.bus_conflict, 1'b0);
    step();
    cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("conf_sticky", bif.bus_conflict, 1'b1);
    step();

    for (int v = 1; v <= 5; v++) cyc(8'h00, 8'h00, 8'h80, 8'(v), 1'b0);
    drive(8'h00, 8'h80, 8'h80, 8'h00, 1'b0);
    check_all();
    chk("ovf_set", bif.out_ovf, 1'b1);
    chk("out_reg_last", bif.bus_out, 8'h05);
    step();
    for (int k = 0; k < 6; k++) cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("drained_valid", bif.out_valid, 1'b0);
    chk("drained_data", bif.out_data, (CAP == 4) ? 8'h04 : 8'h01);
    step();

    do_reset();
    for (int v = 0; v < CAP; v++) cyc(8'h00, 8'h00, 8'h80, 8'(8'h40 + v), 1'b0);
    drive(8'h00, 8'h00, 8'h80, 8'h77, 1'b1);
    check_all();
    chk("full_head", bif.out_data, 8'h40);
    step();
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check_all();
    chk("full_pp_ovf", bif.out_ovf, 1'b0);
    chk("full_pp_head", bif.out_data, (CAP == 1) ? 8'h77 : 8'h41);
    step();
    for (int k = 0; k < CAP + 1; k++) cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    for (int v = 0; v < 3; v++) cyc(8'h00, 8'h00, 8'h80, 8'(8'h90 + v), 1'b0);
    cyc(8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
    do_reset();

    for (int it = 0; it < 400; it++) begin
      if (it % 60 == 59) begin
        do_reset();
      end else begin
        cyc(8'($urandom & $urandom & $urandom), 8'($urandom), 8'($urandom & $urandom),
            8'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
